// File: rtl/fabric_tag_pkg.sv
// -----------------------------------------------------------------------------
// fabric_tag_pkg
// Shared definitions for the tagged-stream dispatcher:
//   tag_dispatch_err_e : 2-bit error codes reported on error_code
//   TD_FIFO_DEPTH      : per-lane FIFO depth
//   TD_TAG_MAX_WIDTH   : widest tag a lane config entry can hold
//   td_cfg_lane_t      : one lane's decoded config entry {en, match_tag}
// -----------------------------------------------------------------------------
package fabric_tag_pkg;

  localparam int TD_FIFO_DEPTH    = 2;
  localparam int TD_TAG_MAX_WIDTH = 32;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_NO_MATCH = 2'd1,
    ERR_DUP_TAG  = 2'd2
  } tag_dispatch_err_e;

  // Tags narrower than TD_TAG_MAX_WIDTH are zero-extended into match_tag.
  typedef struct packed {
    logic                        en;
    logic [TD_TAG_MAX_WIDTH-1:0] match_tag;
  } td_cfg_lane_t;

endpackage

// File: rtl/fabric_fifo2.sv
// -----------------------------------------------------------------------------
// fabric_fifo2
// Two-entry valid/ready FIFO with a registered head. 1-bit wrapping pointers
// and a 2-bit occupancy count (0..2). No bypass: a push into an empty FIFO
// becomes visible on out_valid the following cycle. in_ready depends only on
// occupancy, never on out_ready.
// Ports:
//   clk, rst_n                clock, async active-low reset
//   in_valid/in_ready/in_data push side
//   out_valid/out_ready/out_data pop side
// -----------------------------------------------------------------------------
module fabric_fifo2
  import fabric_tag_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] r_mem [TD_FIFO_DEPTH];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  // A full FIFO refuses the push even if a pop frees a slot this cycle.
  assign in_ready  = (r_count != 2'(TD_FIFO_DEPTH));
  assign out_valid = (r_count != 2'd0);
  assign out_data  = r_mem[r_rd_ptr];

  assign w_push = in_valid && in_ready;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: occupancy alone qualifies it.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= in_data;
  end

endmodule

// File: rtl/fabric_tag_dispatch.sv
// -----------------------------------------------------------------------------
// fabric_tag_dispatch
// Decodes the tag carried in the MSBs of each input token, strips it, and
// steers the value into the FIFO of the matching lane. Lowest-index lane wins
// on multiple hits (ERR_DUP_TAG); tokens with no hit are consumed and dropped
// (ERR_NO_MATCH). The first error is latched until reset.
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    tagged input handshake, in_data = {tag, value}
//   out_valid/out_ready  per-lane handshake, out_data lane i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_data             per-lane {en, match_tag} at [i*(TAG_WIDTH+1) +: TAG_WIDTH+1]
//   error_valid          sticky error flag
//   error_code           first error code captured
//   stat_count           (FABRIC_TAG_DISPATCH_STATS_EN only) per-lane 16-bit
//                        saturating pop counters
// Build option: define FABRIC_TAG_DISPATCH_STATS_EN to add stat_count.
// -----------------------------------------------------------------------------
module fabric_tag_dispatch
  import fabric_tag_pkg::*;
#(
  parameter  int NUM_OUTPUTS   = 2,
  parameter  int DATA_WIDTH    = 32,
  parameter  int TAG_WIDTH     = 4,
  localparam int PAYLOAD_WIDTH = DATA_WIDTH + TAG_WIDTH,
  localparam int CONFIG_WIDTH  = NUM_OUTPUTS * (TAG_WIDTH + 1)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [PAYLOAD_WIDTH-1:0]          in_data,
  output logic [NUM_OUTPUTS-1:0]            out_valid,
  input  logic [NUM_OUTPUTS-1:0]            out_ready,
  output logic [NUM_OUTPUTS*DATA_WIDTH-1:0] out_data,
  input  logic [CONFIG_WIDTH-1:0]           cfg_data,
`ifdef FABRIC_TAG_DISPATCH_STATS_EN
  output logic [NUM_OUTPUTS*16-1:0]         stat_count,
`endif
  output logic                              error_valid,
  output logic [1:0]                        error_code
);

  // Parameter sanity, enforced at elaboration time.
  if (NUM_OUTPUTS < 1) begin : g_bad_outputs
    $fatal(1, "fabric_tag_dispatch: NUM_OUTPUTS must be >= 1");
  end
  if (DATA_WIDTH < 1) begin : g_bad_data
    $fatal(1, "fabric_tag_dispatch: DATA_WIDTH must be >= 1");
  end
  if (TAG_WIDTH < 1 || TAG_WIDTH > TD_TAG_MAX_WIDTH) begin : g_bad_tag
    $fatal(1, "fabric_tag_dispatch: TAG_WIDTH must be in 1..TD_TAG_MAX_WIDTH");
  end

  logic [TAG_WIDTH-1:0]   w_in_tag;
  logic [DATA_WIDTH-1:0]  w_in_value;
  td_cfg_lane_t           w_lane_cfg [NUM_OUTPUTS];
  logic [NUM_OUTPUTS-1:0] w_hit;
  logic [NUM_OUTPUTS-1:0] w_grant;
  logic [NUM_OUTPUTS-1:0] w_fifo_ready;
  logic [NUM_OUTPUTS-1:0] w_push;
  logic                   w_hit_any;
  logic                   w_dup;
  logic                   w_in_ready;
  logic                   w_accept;

  logic                   r_error_valid;
  tag_dispatch_err_e      r_error_code;

  assign w_in_tag   = in_data[PAYLOAD_WIDTH-1 -: TAG_WIDTH];
  assign w_in_value = in_data[DATA_WIDTH-1:0];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_lane
      assign w_lane_cfg[gi] = {cfg_data[gi*(TAG_WIDTH+1) + TAG_WIDTH],
                               TD_TAG_MAX_WIDTH'(cfg_data[gi*(TAG_WIDTH+1) +: TAG_WIDTH])};
      assign w_hit[gi] = w_lane_cfg[gi].en &&
                         (w_lane_cfg[gi].match_tag == TD_TAG_MAX_WIDTH'(w_in_tag));

      fabric_fifo2 #(
        .WIDTH (DATA_WIDTH)
      ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w_push[gi]),
        .in_ready  (w_fifo_ready[gi]),
        .in_data   (w_in_value),
        .out_valid (out_valid[gi]),
        .out_ready (out_ready[gi]),
        .out_data  (out_data[gi*DATA_WIDTH +: DATA_WIDTH])
      );
    end
  endgenerate

  // Isolate the lowest set hit bit: x & -x gives a one-hot grant.
  assign w_grant   = w_hit & (~w_hit + NUM_OUTPUTS'(1));
  assign w_hit_any = |w_hit;
  assign w_dup     = |(w_hit & ~w_grant);

  // Unmatched tokens are always accepted (and dropped).
  assign w_in_ready = w_hit_any ? |(w_grant & w_fifo_ready) : 1'b1;
  assign w_accept   = in_valid && w_in_ready;
  assign w_push     = w_accept ? w_grant : '0;
  assign in_ready   = w_in_ready;

  // Only the first error is recorded; no-match and dup are mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error_valid <= 1'b0;
      r_error_code  <= ERR_NONE;
    end else if (w_accept && !r_error_valid && (w_dup || !w_hit_any)) begin
      r_error_valid <= 1'b1;
      r_error_code  <= w_dup ? ERR_DUP_TAG : ERR_NO_MATCH;
    end
  end

  assign error_valid = r_error_valid;
  assign error_code  = r_error_code;

`ifdef FABRIC_TAG_DISPATCH_STATS_EN
  generate
    for (gi = 0; gi < NUM_OUTPUTS; gi++) begin : g_stat
      logic [15:0] r_stat_cnt;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_stat_cnt <= 16'd0;
        end else if (out_valid[gi] && out_ready[gi] && (r_stat_cnt != 16'hFFFF)) begin
          r_stat_cnt <= r_stat_cnt + 16'd1;
        end
      end

      assign stat_count[gi*16 +: 16] = r_stat_cnt;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fabric_tag_dispatch.sv
// -----------------------------------------------------------------------------
// tb_fabric_tag_dispatch
// Table of directed per-cycle vectors, hand-written reset/dup sequences and a
// randomized run checked against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_fabric_tag_dispatch;

  localparam int NO = 2;
  localparam int DW = 32;
  localparam int TW = 4;

  localparam logic [9:0] CFG_N = {1'b1, 4'h5, 1'b1, 4'h3}; // lane0=3, lane1=5
  localparam logic [9:0] CFG_D = {1'b1, 4'h3, 1'b1, 4'h3}; // both lanes tag 3

  logic           clk = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [DW+TW-1:0] in_data;
  logic [NO-1:0]  out_valid;
  logic [NO-1:0]  out_ready;
  logic [NO*DW-1:0] out_data;
  logic [9:0]     cfg_data;
  logic           error_valid;
  logic [1:0]     error_code;
`ifdef FABRIC_TAG_DISPATCH_STATS_EN
  logic [NO*16-1:0] stat_count;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fabric_tag_dispatch #(
    .NUM_OUTPUTS (NO),
    .DATA_WIDTH  (DW),
    .TAG_WIDTH   (TW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .cfg_data    (cfg_data),
`ifdef FABRIC_TAG_DISPATCH_STATS_EN
    .stat_count  (stat_count),
`endif
    .error_valid (error_valid),
    .error_code  (error_code)
  );

  typedef struct {
    logic [9:0]  cfg;
    logic        v;
    logic [3:0]  tag;
    logic [31:0] val;
    logic [1:0]  ordy;
    logic        e_ir;
    logic [1:0]  e_ov;
    logic [31:0] e_d0;
    logic [31:0] e_d1;
    logic        e_ev;
    logic [1:0]  e_ec;
  } vec_t;

  vec_t tbl [23];

  function automatic vec_t mk(input logic [9:0] cfg, input logic v, input logic [3:0] tag,
                              input logic [31:0] val, input logic [1:0] ordy, input logic e_ir,
                              input logic [1:0] e_ov, input logic [31:0] e_d0,
                              input logic [31:0] e_d1, input logic e_ev, input logic [1:0] e_ec);
    vec_t r;
    r.cfg = cfg; r.v = v; r.tag = tag; r.val = val; r.ordy = ordy;
    r.e_ir = e_ir; r.e_ov = e_ov; r.e_d0 = e_d0; r.e_d1 = e_d1;
    r.e_ev = e_ev; r.e_ec = e_ec;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] tag, input logic [31:0] val,
                       input logic [1:0] ordy);
    in_valid  = v;
    in_data   = {tag, val};
    out_ready = ordy;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 4'h0, 32'h0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Reference model state: per-lane queues of values plus first-error record.
  logic [31:0] mq0 [$];
  logic [31:0] mq1 [$];
  logic        m_ev;
  logic [1:0]  m_ec;

  function automatic int qsize(input int lane);
    return (lane == 0) ? mq0.size() : mq1.size();
  endfunction

  initial begin
    int          hit;
    bit          dup;
    logic        m_ready;
    logic        v;
    logic [3:0]  tag;
    logic [31:0] val;
    logic [1:0]  ordy;

    cfg_data = CFG_N;
    do_reset();

    // ---- reset state ----
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'h0);
    chk("reset_err_valid", 64'(error_valid), 64'h0);
    chk("reset_err_code",  64'(error_code), 64'h0);
`ifdef FABRIC_TAG_DISPATCH_STATS_EN
    chk("reset_stats", 64'(stat_count), 64'h0);
`endif
    next_cycle();

    // ---- directed table: routing, backpressure, no-match, cfg change, streaming ----
    tbl[0]  = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b00, 0, 0, 0, 0);
    tbl[1]  = mk(CFG_N, 1, 5, 32'hAA, 2'b11, 1, 2'b00, 0, 0, 0, 0);
    tbl[2]  = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b10, 0, 32'hAA, 0, 0);
    tbl[3]  = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b00, 0, 0, 0, 0);
    tbl[4]  = mk(CFG_N, 1, 3, 32'h1,  2'b00, 1, 2'b00, 0, 0, 0, 0);
    tbl[5]  = mk(CFG_N, 1, 3, 32'h2,  2'b00, 1, 2'b01, 32'h1, 0, 0, 0);
    tbl[6]  = mk(CFG_N, 1, 3, 32'h3,  2'b00, 0, 2'b01, 32'h1, 0, 0, 0);
    tbl[7]  = mk(CFG_N, 1, 3, 32'h3,  2'b01, 0, 2'b01, 32'h1, 0, 0, 0);
    tbl[8]  = mk(CFG_N, 1, 3, 32'h3,  2'b01, 1, 2'b01, 32'h2, 0, 0, 0);
    tbl[9]  = mk(CFG_N, 0, 0, 32'h0,  2'b01, 1, 2'b01, 32'h3, 0, 0, 0);
    tbl[10] = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b00, 0, 0, 0, 0);
    tbl[11] = mk(CFG_N, 1, 7, 32'h77, 2'b11, 1, 2'b00, 0, 0, 0, 0);
    tbl[12] = mk(CFG_N, 1, 5, 32'hBB, 2'b11, 1, 2'b00, 0, 0, 1, 1);
    tbl[13] = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b10, 0, 32'hBB, 1, 1);
    tbl[14] = mk(CFG_D, 0, 0, 32'h0,  2'b11, 1, 2'b00, 0, 0, 1, 1);
    tbl[15] = mk(CFG_D, 1, 3, 32'hCC, 2'b11, 1, 2'b00, 0, 0, 1, 1);
    tbl[16] = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b01, 32'hCC, 0, 1, 1);
    tbl[17] = mk(CFG_N, 1, 3, 32'h10, 2'b11, 1, 2'b00, 0, 0, 1, 1);
    tbl[18] = mk(CFG_N, 1, 5, 32'h11, 2'b11, 1, 2'b01, 32'h10, 0, 1, 1);
    tbl[19] = mk(CFG_N, 1, 3, 32'h12, 2'b11, 1, 2'b10, 0, 32'h11, 1, 1);
    tbl[20] = mk(CFG_N, 1, 5, 32'h13, 2'b11, 1, 2'b01, 32'h12, 0, 1, 1);
    tbl[21] = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b10, 0, 32'h13, 1, 1);
    tbl[22] = mk(CFG_N, 0, 0, 32'h0,  2'b11, 1, 2'b00, 0, 0, 1, 1);

    for (int r = 0; r < 23; r++) begin
      cfg_data = tbl[r].cfg;
      drive(tbl[r].v, tbl[r].tag, tbl[r].val, tbl[r].ordy);
      @(negedge clk);
      $display("row %0d: v=%0b tag=%0h val=%0h ordy=%b -> ir=%0b ov=%b err=%0b/%0d",
               r, tbl[r].v, tbl[r].tag, tbl[r].val, tbl[r].ordy,
               in_ready, out_valid, error_valid, error_code);
      chk($sformatf("row%0d_in_ready", r), 64'(in_ready), 64'(tbl[r].e_ir));
      chk($sformatf("row%0d_out_valid", r), 64'(out_valid), 64'(tbl[r].e_ov));
      if (tbl[r].e_ov[0]) chk($sformatf("row%0d_data0", r), 64'(out_data[31:0]), 64'(tbl[r].e_d0));
      if (tbl[r].e_ov[1]) chk($sformatf("row%0d_data1", r), 64'(out_data[63:32]), 64'(tbl[r].e_d1));
      chk($sformatf("row%0d_err_valid", r), 64'(error_valid), 64'(tbl[r].e_ev));
      chk($sformatf("row%0d_err_code", r), 64'(error_code), 64'(tbl[r].e_ec));
      next_cycle();
    end

    // ---- duplicate tag on a fresh error record ----
    do_reset();
    cfg_data = CFG_D;
    drive(1'b1, 4'h3, 32'hDD, 2'b00);
    next_cycle();
    drive(1'b0, 4'h0, 32'h0, 2'b00);
    @(negedge clk);
    $display("dup: ov=%b err=%0b/%0d", out_valid, error_valid, error_code);
    chk("dup_out_valid", 64'(out_valid), 64'h1);
    chk("dup_data0", 64'(out_data[31:0]), 64'hDD);
    chk("dup_err_valid", 64'(error_valid), 64'h1);
    chk("dup_err_code", 64'(error_code), 64'h2);
    next_cycle();

    // ---- reset mid-operation with both FIFOs full ----
    cfg_data = CFG_N;
    drive(1'b1, 4'h3, 32'hE1, 2'b00); next_cycle(); // lane0 now DD,E1
    drive(1'b1, 4'h5, 32'hF1, 2'b00); next_cycle();
    drive(1'b1, 4'h5, 32'hF2, 2'b00); next_cycle();
    drive(1'b1, 4'h3, 32'hE2, 2'b00);
    @(negedge clk);
    chk("full_out_valid", 64'(out_valid), 64'h3);
    chk("full_in_ready", 64'(in_ready), 64'h0);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: ov=%b err=%0b", out_valid, error_valid);
    chk("async_rst_out_valid", 64'(out_valid), 64'h0);
    chk("async_rst_err_valid", 64'(error_valid), 64'h0);
    drive(1'b0, 4'h0, 32'h0, 2'b11);
    next_cycle();
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_out_valid", 64'(out_valid), 64'h0);
    chk("post_rst_err_code", 64'(error_code), 64'h0);
`ifdef FABRIC_TAG_DISPATCH_STATS_EN
    chk("post_rst_stats", 64'(stat_count), 64'h0);
`endif
    next_cycle();
    drive(1'b1, 4'h5, 32'h55, 2'b11);
    next_cycle();
    drive(1'b0, 4'h0, 32'h0, 2'b11);
    @(negedge clk);
    chk("post_rst_route_valid", 64'(out_valid), 64'h2);
    chk("post_rst_route_data", 64'(out_data[63:32]), 64'h55);
    next_cycle();
    @(negedge clk);
    chk("post_rst_single_entry", 64'(out_valid), 64'h0);
    next_cycle();

    // ---- randomized traffic against the queue model ----
    do_reset();
    mq0.delete(); mq1.delete();
    m_ev = 1'b0; m_ec = 2'd0;
    for (int c = 0; c < 400; c++) begin
      if (c % 64 == 0) begin
        cfg_data = {($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 7))};
      end
      v    = ($urandom_range(0, 9) < 7);
      tag  = 4'($urandom_range(0, 7));
      val  = $urandom;
      ordy = 2'($urandom_range(0, 3));
      drive(v, tag, val, ordy);

      hit = -1; dup = 0;
      for (int i = 0; i < NO; i++) begin
        if (cfg_data[i*5+4] && cfg_data[i*5 +: 4] == tag) begin
          if (hit < 0) hit = i;
          else dup = 1;
        end
      end
      m_ready = (hit < 0) || (qsize(hit) < 2);

      @(negedge clk);
      chk($sformatf("rnd%0d_in_ready", c), 64'(in_ready), 64'(m_ready));
      chk($sformatf("rnd%0d_ov0", c), 64'(out_valid[0]), 64'(mq0.size() != 0));
      chk($sformatf("rnd%0d_ov1", c), 64'(out_valid[1]), 64'(mq1.size() != 0));
      if (mq0.size() != 0) chk($sformatf("rnd%0d_d0", c), 64'(out_data[31:0]), 64'(mq0[0]));
      if (mq1.size() != 0) chk($sformatf("rnd%0d_d1", c), 64'(out_data[63:32]), 64'(mq1[0]));
      chk($sformatf("rnd%0d_err_valid", c), 64'(error_valid), 64'(m_ev));
      chk($sformatf("rnd%0d_err_code", c), 64'(error_code), 64'(m_ec));

      if (ordy[0] && mq0.size() != 0) void'(mq0.pop_front());
      if (ordy[1] && mq1.size() != 0) void'(mq1.pop_front());
      if (v && m_ready) begin
        $display("rnd %0d: tag=%0h val=%0h -> lane %0d%s", c, tag, val, hit, dup ? " (dup)" : "");
        if (hit == 0) mq0.push_back(val);
        if (hit == 1) mq1.push_back(val);
        if (!m_ev && (hit < 0 || dup)) begin
          m_ev = 1'b1;
          m_ec = dup ? 2'd2 : 2'd1;
        end
      end
      next_cycle();
    end

`ifdef FABRIC_TAG_DISPATCH_STATS_EN
    // ---- pop counter saturation on lane1 ----
    do_reset();
    cfg_data = CFG_N;
    for (int i = 0; i < 65540; i++) begin
      drive(1'b1, 4'h5, 32'(i), 2'b11);
      next_cycle();
    end
    drive(1'b0, 4'h0, 32'h0, 2'b11);
    next_cycle();
    @(negedge clk);
    $display("stats: lane0=%0h lane1=%0h", stat_count[15:0], stat_count[31:16]);
    chk("stat_lane1_saturated", 64'(stat_count[31:16]), 64'hFFFF);
    chk("stat_lane0_idle", 64'(stat_count[15:0]), 64'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
